uart_tx_arbiter: RTL and testbench



---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_arbiter_if.sv | 23 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 111 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame length, byte type and the arbiter state encoding.
package uart_pkg;

    // start bit + 8 data bits + stop bit
    localparam int UART_FRAME_BITS = 10;

    typedef logic [7:0] uart_byte_t;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT
    } tx_arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side bus of the UART arbiter: per-requester valid/data with a one-hot ready.
// Requester k owns req_data[8k+7:8k].
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ*8-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;

    // Producers drive valid/data and watch ready.
    modport master (
        output req_valid,
        output req_data,
        input  req_ready
    );

    // The arbiter samples valid/data and returns the accept strobe.
    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority pick: the first set request found scanning
// upward from ptr (wrapping modulo N) wins. The pointer itself lives in the caller.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any_req
);

    // Rotated scan; once a winner is found, later positions are ignored.
    always_comb begin
        logic [IW-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        idx       = '0;
        for (int i = 0; i < N; i++) begin
            idx = IW'((int'(ptr) + i) % N);
            if (!any_req && req[idx]) begin
                any_req    = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among N_REQ byte producers. A byte is accepted in IDLE,
// tx_send is pulsed for SEND_CYCLES, and further grants are held off until a
// full frame plus guard time has elapsed since the send started.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int CLKS_PER_BIT = 868,
    parameter int SEND_CYCLES  = 2,
    parameter int GUARD_CLKS   = 16,
    localparam int GRANT_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_tx_arbiter_if.slave   req_if,
    input  logic               rx_ready_i,
    output logic               tx_send_o,
    output uart_byte_t         tx_data_o,
    output logic               busy_o,
    output logic [GRANT_W-1:0] grant_id_o
);

    localparam int FRAME_CLKS = UART_FRAME_BITS * CLKS_PER_BIT + GUARD_CLKS;
    localparam int TIMER_W    = $clog2(FRAME_CLKS);

    tx_arb_state_e      state_reg;
    logic [GRANT_W-1:0] ptr_reg;
    logic [TIMER_W-1:0] timer_reg;
    logic               tx_send_reg;
    uart_byte_t         tx_data_reg;
    logic               busy_reg;
    logic [GRANT_W-1:0] grant_id_reg;

    logic [N_REQ-1:0]   rr_grant;
    logic [GRANT_W-1:0] rr_idx;
    logic               rr_any;
    logic               accept;
    logic [GRANT_W-1:0] ptr_next;
    uart_byte_t         req_bytes [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign req_bytes[gi] = req_if.req_data[8*gi +: 8];
    end

    rr_arbiter #(
        .N  (N_REQ),
        .IW (GRANT_W)
    ) u_rr (
        .req       (req_if.req_valid),
        .ptr       (ptr_reg),
        .grant     (rr_grant),
        .grant_idx (rr_idx),
        .any_req   (rr_any)
    );

    // Accept only from IDLE with the far end ready; reset masks the strobe so a
    // producer never sees a handshake that the registers will not honour.
    assign accept           = (state_reg == IDLE) && rst_n && rx_ready_i && rr_any;
    assign req_if.req_ready = {N_REQ{accept}} & rr_grant;
    assign ptr_next         = (rr_idx == GRANT_W'(N_REQ - 1)) ? '0 : rr_idx + 1'b1;

    // Frame sequencer; the timer runs from SEND entry through the end of WAIT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            timer_reg    <= '0;
            tx_send_reg  <= 1'b0;
            tx_data_reg  <= 8'h00;
            busy_reg     <= 1'b0;
            grant_id_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        tx_data_reg  <= req_bytes[rr_idx];
                        grant_id_reg <= rr_idx;
                        ptr_reg      <= ptr_next;
                        timer_reg    <= '0;
                        tx_send_reg  <= 1'b1;
                        busy_reg     <= 1'b1;
                        state_reg    <= SEND;
                    end
                end
                SEND: begin
                    timer_reg <= timer_reg + 1'b1;
                    if (timer_reg == TIMER_W'(SEND_CYCLES - 1)) begin
                        tx_send_reg <= 1'b0;
                        state_reg   <= WAIT;
                    end
                end
                WAIT: begin
                    if (timer_reg == TIMER_W'(FRAME_CLKS - 1)) begin
                        timer_reg <= '0;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign tx_send_o  = tx_send_reg;
    assign tx_data_o  = tx_data_reg;
    assign busy_o     = busy_reg;
    assign grant_id_o = grant_id_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios followed by a random phase, all
// checked cycle by cycle against a frame-level reference model.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int N     = 4;
    localparam int CPB   = 4;
    localparam int SC    = 2;
    localparam int GC    = 2;
    localparam int FRAME = 10 * CPB + GC;   // 42

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_ready = 1'b0;
    logic       tx_send;
    logic [7:0] tx_data;
    logic       busy;
    logic [1:0] gid;

    uart_tx_arbiter_if #(.N_REQ(N)) req_if ();

    uart_tx_arbiter #(
        .N_REQ        (N),
        .CLKS_PER_BIT (CPB),
        .SEND_CYCLES  (SC),
        .GUARD_CLKS   (GC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_if     (req_if),
        .rx_ready_i (rx_ready),
        .tx_send_o  (tx_send),
        .tx_data_o  (tx_data),
        .busy_o     (busy),
        .grant_id_o (gid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Requester-side stimulus state.
    logic [N-1:0] valid = '0;
    logic [7:0]   data [N];
    bit           hold_after = 1'b0;   // keep valid after a handshake

    // Reference model: a frame is a window of FRAME cycles starting when the
    // byte is taken; tx_send covers the first SC cycles of that window.
    bit         m_busy = 1'b0;
    int         m_elapsed = 0;
    int         m_ptr = 0;
    int         m_gid = 0;
    logic [7:0] m_data = 8'h00;

    // Observation logs.
    int cyc = 0;
    int rise_q[$];
    int gnt_q[$];
    int send_hi = 0;
    int busy_hi = 0;
    bit prev_send = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    // First valid requester in round-robin order from the model pointer, or -1.
    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            if (valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    // One clock: drive, check everything, advance the model on the edge.
    task automatic step();
        logic [N-1:0] er;
        int           s;
        req_if.req_valid = valid;
        for (int k = 0; k < N; k++) req_if.req_data[8*k +: 8] = data[k];
        #1;
        er = '0;
        s  = pick();
        if (rst_n && !m_busy && rx_ready && s >= 0) er[s] = 1'b1;
        chk("req_ready", req_if.req_ready, er);
        chk("ready_onehot", ($countones(req_if.req_ready) <= 1), 1);
        chk("tx_send", tx_send, (m_busy && m_elapsed < SC));
        chk("tx_data", tx_data, m_data);
        chk("busy", busy, m_busy);
        chk("grant_id", gid, m_gid);
        if (tx_send === 1'b1) send_hi++;
        if (busy === 1'b1) busy_hi++;
        if (tx_send === 1'b1 && !prev_send) rise_q.push_back(cyc);
        prev_send = (tx_send === 1'b1);
        @(posedge clk);
        if (!rst_n) begin
            m_busy = 1'b0; m_elapsed = 0; m_ptr = 0; m_gid = 0; m_data = 8'h00;
        end else if (m_busy) begin
            if (m_elapsed == FRAME - 1) m_busy = 1'b0;
            else m_elapsed++;
        end else if (er != '0) begin
            m_data = data[s]; m_gid = s; m_ptr = (s + 1) % N;
            m_busy = 1'b1; m_elapsed = 0;
            gnt_q.push_back(s);
            $display("cycle %0d: grant requester %0d data %02h", cyc, s, data[s]);
            if (!hold_after) valid[s] = 1'b0;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Withdraw all requests and let the current frame finish (bounded).
    task automatic drain();
        valid = '0;
        for (int i = 0; i < 2 * FRAME && m_busy; i++) step();
        step();
        chk("drain_idle", busy, 1'b0);
    endtask

    task automatic clear_logs();
        rise_q.delete(); gnt_q.delete(); send_hi = 0; busy_hi = 0;
    endtask

    initial begin
        int n0;
        for (int k = 0; k < N; k++) data[k] = 8'hA0 + 8'(k);
        req_if.req_valid = '0;
        req_if.req_data  = '0;

        // Reset with every requester valid: nothing may be accepted.
        rst_n = 1'b0; rx_ready = 1'b1; valid = 4'b1111;
        @(posedge clk); @(negedge clk);
        run(5);
        chk("rst_no_grant", gnt_q.size(), 0);
        rst_n = 1'b1;
        step();
        chk("rst_first_grant_cnt", gnt_q.size(), 1);
        if (gnt_q.size() == 1) chk("rst_first_grant_id", gnt_q[0], 0);
        drain();

        // Single request from requester 2.
        clear_logs();
        valid = 4'b0100; data[2] = 8'h55;
        run(50);
        chk("single_grant_cnt", gnt_q.size(), 1);
        if (gnt_q.size() == 1) chk("single_grant_id", gnt_q[0], 2);
        chk("single_send_cycles", send_hi, SC);
        chk("single_busy_cycles", busy_hi, FRAME);
        drain();

        // Round-robin with all four continuously valid, starting from pointer 0.
        rst_n = 1'b0; step(); rst_n = 1'b1;
        clear_logs();
        hold_after = 1'b1;
        for (int k = 0; k < N; k++) data[k] = 8'hA0 + 8'(k);
        valid = 4'b1111;
        run(5 * (FRAME + 1) + 4);
        chk("rr_grant_cnt", (gnt_q.size() >= 5), 1);
        if (gnt_q.size() >= 5)
            for (int i = 0; i < 5; i++) chk("rr_order", gnt_q[i], i % N);
        chk("rr_rise_cnt", (rise_q.size() >= 5), 1);
        if (rise_q.size() >= 5)
            for (int i = 0; i < 4; i++) chk("rr_spacing", rise_q[i+1] - rise_q[i], FRAME + 1);
        hold_after = 1'b0;
        drain();

        // Flow control: blocked while rx_ready is low, granted on its rise.
        clear_logs();
        rx_ready = 1'b0; valid = 4'b0010; data[1] = 8'h3C;
        run(100);
        chk("flow_blocked_grants", gnt_q.size(), 0);
        chk("flow_blocked_send", send_hi, 0);
        rx_ready = 1'b1;
        busy_hi = 0;
        step();
        chk("flow_grant_on_rise", gnt_q.size(), 1);
        run(10);
        rx_ready = 1'b0;
        run(60);
        chk("flow_frame_len", busy_hi, FRAME);
        rx_ready = 1'b1;
        drain();

        // Mid-frame reset during requester 3's WAIT, requester 0 pending.
        clear_logs();
        valid = 4'b1001; data[0] = 8'h0F; data[3] = 8'hF3;
        step();
        chk("midrst_first", (gnt_q.size() == 1) ? gnt_q[0] : -1, 3);
        run(10);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_send", tx_send, 1'b0);
        step();
        chk("midrst_regrant", gnt_q.size(), 2);
        if (gnt_q.size() == 2) chk("midrst_regrant_id", gnt_q[1], 0);

        // Requester 1 appears during WAIT and withdraws before IDLE.
        run(5);
        valid[1] = 1'b1; data[1] = 8'h77;
        run(10);
        valid[1] = 1'b0;
        n0 = gnt_q.size();
        drain();
        chk("withdraw_no_grant", gnt_q.size(), n0);
        valid = 4'b0110; data[1] = 8'h11; data[2] = 8'h22;
        step();
        chk("withdraw_ptr_kept", (gnt_q.size() == n0 + 1) ? gnt_q[n0] : -1, 1);
        drain();

        // Random phase: arrivals, withdrawals and rx_ready toggling.
        for (int i = 0; i < 2500; i++) begin
            for (int k = 0; k < N; k++) begin
                if (!valid[k] && $urandom_range(0, 15) == 0) begin
                    valid[k] = 1'b1;
                    data[k]  = 8'($urandom);
                end else if (valid[k] && $urandom_range(0, 199) == 0) begin
                    valid[k] = 1'b0;
                end
            end
            if ($urandom_range(0, 29) == 0) rx_ready = ~rx_ready;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
